// File: rtl/log_to_linear.sv
// LogNumber to signed fixed-point converter, serial shifter with valid/ready handshake.
// Define LOG_TO_LINEAR_ROUND_EN to round right-shifted results half up instead of truncating.
module log_to_linear #(
    parameter int M         = 3,
    parameter int F         = 4,
    parameter int OUT_WIDTH = 8,
    parameter int OUT_FRAC  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [M+F:0]         in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sat,
    output logic                 out_inf
);
    localparam int MW = OUT_WIDTH - 1;
    localparam logic [OUT_WIDTH-1:0] MAXP = {1'b0, {MW{1'b1}}};

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    // Evaluated only at elaboration to build the mantissa table.
    function automatic int mant_of(input int k);
        real x;
        x = (2.0 ** F) * (2.0 ** (real'(k) / (2.0 ** F)));
        return $rtoi(x + 0.5);
    endfunction

    function automatic logic [OUT_WIDTH-1:0] fin(
        input logic [MW-1:0] m,
        input logic          ng,
        input logic          st
    );
        logic [OUT_WIDTH-1:0] v;
        v = st ? MAXP : {1'b0, m};
        return ng ? (~v + 1'b1) : v;
    endfunction

    logic [F:0] mant [2**F];
    for (genvar g = 0; g < 2**F; g++) begin : g_mant
        assign mant[g] = (F+1)'(mant_of(g));
    end

    state_t        state;
    logic [M+F:0]  din;
    logic [MW-1:0] mag;
    logic [15:0]   cnt;
    logic          left;
    logic          neg;
    logic          sat;

    logic          sgn_i;
    logic [M-1:0]  le;
    logic [F-1:0]  lf;
    logic          special;
    int            s_i;
    int            n_i;
    logic [MW-1:0] mant_i;

    assign {sgn_i, le, lf} = din;
    assign special = &din[M+F-1:0];
    assign mant_i  = MW'(mant[lf]);

    always_comb begin
        s_i = int'(le) - 2**(M-1) + OUT_FRAC - F;
        n_i = 0;
        if (s_i > 0)
            n_i = s_i;
        else if (-s_i > F + 2)
            n_i = F + 2;
        else
            n_i = -s_i;
    end

    logic [MW-1:0] shl;
    logic [MW-1:0] shr;
    logic [MW:0]   rnd;
    logic [MW-1:0] nmag;
    logic          nsat;

    assign shl = mag << 1;
    assign shr = mag >> 1;
`ifdef LOG_TO_LINEAR_ROUND_EN
    assign rnd = {1'b0, shr} + {{MW{1'b0}}, mag[0]};
`else
    assign rnd = {1'b0, shr};
`endif

    // Rounding only applies to the final right shift.
    always_comb begin
        nmag = shr;
        nsat = sat;
        if (left) begin
            nmag = shl;
            nsat = sat | mag[MW-1];
        end else if (cnt == 16'd1) begin
            nmag = rnd[MW-1:0];
            nsat = sat | rnd[MW];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            din       <= '0;
            mag       <= '0;
            cnt       <= '0;
            left      <= 1'b0;
            neg       <= 1'b0;
            sat       <= 1'b0;
            in_ready  <= 1'b1;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
            out_inf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    din      <= in_data;
                    in_ready <= 1'b0;
                    state    <= LOAD;
                end
                LOAD: begin
                    sat  <= 1'b0;
                    neg  <= sgn_i;
                    mag  <= mant_i;
                    cnt  <= 16'(n_i);
                    left <= s_i > 0;
                    if (special) begin
                        out_data  <= sgn_i ? MAXP : '0;
                        out_sat   <= sgn_i;
                        out_inf   <= sgn_i;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (n_i == 0) begin
                        out_data  <= fin(mant_i, sgn_i, 1'b0);
                        out_sat   <= 1'b0;
                        out_inf   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    mag <= nmag;
                    sat <= nsat;
                    cnt <= cnt - 16'd1;
                    if (cnt == 16'd1) begin
                        out_data  <= fin(nmag, neg, nsat);
                        out_sat   <= nsat;
                        out_inf   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_log_to_linear.sv
// Directed bench for log_to_linear at M=3 F=4 OUT_WIDTH=8 OUT_FRAC=4.
module tb_log_to_linear;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_sat;
    logic       out_inf;

    int errors = 0;
    int checks = 0;

    log_to_linear #(.M(3), .F(4), .OUT_WIDTH(8), .OUT_FRAC(4)) dut (
        .clock(clock),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sat(out_sat),
        .out_inf(out_inf)
    );

    always #5 clock = ~clock;

    // lat counts cycles from the accept cycle (0) to the first out_valid cycle.
    task automatic run(input logic [7:0] d, output int lat,
                       output logic [7:0] od, output logic os, output logic oi);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        od = out_data;
        os = out_sat;
        oi = out_inf;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", out_data); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL reset_sat got %b want 0", out_sat); end
        checks++; if (out_inf !== 1'b0) begin errors++; $display("FAIL reset_inf got %b want 0", out_inf); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
    endtask

    task automatic test_unity();
        int lat; logic [7:0] d; logic s, i;
        run(8'b0_100_0000, lat, d, s, i);
        checks++; if (lat !== 2) begin errors++; $display("FAIL pos1_lat got %0d want 2", lat); end
        checks++; if (d !== 8'h10) begin errors++; $display("FAIL pos1_data got %h want 10", d); end
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL pos1_sat got %b want 0", s); end
        drain();
    endtask

    task automatic test_backpressure();
        int lat; logic [7:0] d; logic s, i;
        run(8'b1_100_0000, lat, d, s, i);
        checks++; if (lat !== 2) begin errors++; $display("FAIL neg1_lat got %0d want 2", lat); end
        checks++; if (d !== 8'hF0) begin errors++; $display("FAIL neg1_data got %h want f0", d); end
        in_data  = 8'b0_100_0000;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            checks++; if (out_data !== 8'hF0) begin errors++; $display("FAIL hold_data c%0d got %h want f0", c, out_data); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid c%0d got %b want 1", c, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready c%0d got %b want 0", c, in_ready); end
        end
        in_valid = 1'b0;
        drain();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL after_drain_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL after_drain_valid got %b want 0", out_valid); end
    endtask

    task automatic test_left_shift();
        int lat; logic [7:0] d; logic s, i;
        run(8'b0_111_1110, lat, d, s, i);
        checks++; if (lat !== 5) begin errors++; $display("FAIL lsat_lat got %0d want 5", lat); end
        checks++; if (d !== 8'h7F) begin errors++; $display("FAIL lsat_data got %h want 7f", d); end
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL lsat_sat got %b want 1", s); end
        checks++; if (i !== 1'b0) begin errors++; $display("FAIL lsat_inf got %b want 0", i); end
        drain();
        run(8'b0_110_0000, lat, d, s, i);
        checks++; if (lat !== 4) begin errors++; $display("FAIL l2_lat got %0d want 4", lat); end
        checks++; if (d !== 8'h40) begin errors++; $display("FAIL l2_data got %h want 40", d); end
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL l2_sat got %b want 0", s); end
        drain();
        run(8'b1_110_1000, lat, d, s, i);
        checks++; if (d !== 8'hA4) begin errors++; $display("FAIL l2neg_data got %h want a4", d); end
        drain();
        run(8'b1_111_0000, lat, d, s, i);
        checks++; if (d !== 8'h81) begin errors++; $display("FAIL negsat_data got %h want 81", d); end
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL negsat_sat got %b want 1", s); end
        drain();
    endtask

    task automatic test_right_shift();
        int lat; logic [7:0] d; logic s, i;
        logic [7:0] want;
`ifdef LOG_TO_LINEAR_ROUND_EN
        want = 8'd3;
`else
        want = 8'd2;
`endif
        run(8'b0_001_1000, lat, d, s, i);
        checks++; if (lat !== 5) begin errors++; $display("FAIL r3_lat got %0d want 5", lat); end
        checks++; if (d !== want) begin errors++; $display("FAIL r3_data got %h want %h", d, want); end
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL r3_sat got %b want 0", s); end
        drain();
        run(8'b1_000_0000, lat, d, s, i);
        checks++; if (lat !== 6) begin errors++; $display("FAIL r4_lat got %0d want 6", lat); end
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL r4_data got %h want ff", d); end
        drain();
    endtask

    task automatic test_zero_inf();
        int lat; logic [7:0] d; logic s, i;
        run(8'b0_111_1111, lat, d, s, i);
        checks++; if (lat !== 2) begin errors++; $display("FAIL zero_lat got %0d want 2", lat); end
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL zero_data got %h want 00", d); end
        checks++; if ({s, i} !== 2'b00) begin errors++; $display("FAIL zero_flags got %b want 00", {s, i}); end
        drain();
        run(8'b1_111_1111, lat, d, s, i);
        checks++; if (lat !== 2) begin errors++; $display("FAIL inf_lat got %0d want 2", lat); end
        checks++; if (d !== 8'h7F) begin errors++; $display("FAIL inf_data got %h want 7f", d); end
        checks++; if ({s, i} !== 2'b11) begin errors++; $display("FAIL inf_flags got %b want 11", {s, i}); end
        drain();
    endtask

    task automatic test_reset_midshift();
        int lat; logic [7:0] d; logic s, i;
        logic seen;
        in_data  = 8'b0_111_1110;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        #2 reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clock); #1;
            seen |= out_valid;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", seen); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", in_ready); end
        run(8'b0_100_0000, lat, d, s, i);
        checks++; if (d !== 8'h10) begin errors++; $display("FAIL post_abort_data got %h want 10", d); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL post_abort_lat got %0d want 2", lat); end
        drain();
    endtask

    initial begin
        test_reset();
        test_unity();
        test_backpressure();
        test_left_shift();
        test_right_shift();
        test_zero_inf();
        test_reset_midshift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
